// File: rtl/lattice_sweep_ctrl_pkg.sv
// rtl/lattice_sweep_ctrl_pkg.sv - shared types and helpers for the lattice sweep sequencer
package lattice_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SWEEP,
        ST_DRAIN,
        ST_FIN
    } state_e;

    localparam int LANES = 4;

    // ceil((x+1)/LANES): node groups in a layer whose top node index is x
    function automatic logic [16:0] group_count(input logic [16:0] x);
        logic [17:0] sum;
        sum = {1'b0, x} + 18'd4;
        return sum[18-1:2];
    endfunction

    // lane i of group grp is live iff its node index 4*grp+i does not exceed s
    function automatic logic [LANES-1:0] lane_mask(input logic [16:0] grp, input logic [15:0] s);
        logic [LANES-1:0] m;
        logic [18:0]      node;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            node = {grp, 2'b00} + 19'(i);
            m[i] = (node <= {3'b000, s});
        end
        return m;
    endfunction

endpackage

// File: rtl/lattice_wr_delay.sv
// rtl/lattice_wr_delay.sv - DEPTH-deep write token delay line matching node-memory read latency
module lattice_wr_delay
    import lattice_sweep_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [AW-1:0]    in_addr,
    input  logic [LANES-1:0] in_mask,
    input  logic [15:0]      in_step,
    output logic             out_valid,
    output logic [AW-1:0]    out_addr,
    output logic [LANES-1:0] out_mask,
    output logic [15:0]      out_step
);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [LANES-1:0] mask_q [DEPTH];
    logic [15:0]      step_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                step_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            mask_q[0]  <= in_mask;
            step_q[0]  <= in_step;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
                mask_q[i]  <= mask_q[i-1];
                step_q[i]  <= step_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign out_mask  = mask_q[DEPTH-1];
    assign out_step  = step_q[DEPTH-1];

endmodule

// File: rtl/lattice_sweep_ctrl.sv
// rtl/lattice_sweep_ctrl.sv - backward-induction sweep sequencer for the 4-lane binomial lattice
// Optional LATTICE_SWEEP_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module lattice_sweep_ctrl
    import lattice_sweep_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       num_steps,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              init_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANES-1:0]  wr_mask,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic [15:0]       wr_step
`ifdef LATTICE_SWEEP_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam logic [16:0] MAX_GROUPS = 17'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d, s_q, s_d;
    logic [ADDR_W:0]   k_q, k_d;
    logic              err_q, err_d;

    logic [16:0]       w_n, w_s, r_s, k_ext, grp;
    logic              too_big, push;
    logic              dl_valid;
    logic [ADDR_W-1:0] dl_addr;
    logic [LANES-1:0]  dl_mask;
    logic [15:0]       dl_step;

    assign w_n     = group_count({1'b0, n_q});
    assign w_s     = group_count({1'b0, s_q});
    assign r_s     = group_count({1'b0, s_q} + 17'd1);
    assign k_ext   = 17'(k_q);
    assign grp     = k_ext - 17'd1;
    // the read window of layer N+1 must fit the group address space
    assign too_big = group_count({1'b0, num_steps} + 17'd1) > MAX_GROUPS;
    assign push    = (state_q == ST_SWEEP) && (k_q != '0);

    lattice_wr_delay #(.DEPTH(RD_LAT), .AW(ADDR_W)) u_wr_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_addr   (push ? grp[ADDR_W-1:0] : '0),
        .in_mask   (push ? lane_mask(grp, s_q) : '0),
        .in_step   (push ? s_q : '0),
        .out_valid (dl_valid),
        .out_addr  (dl_addr),
        .out_mask  (dl_mask),
        .out_step  (dl_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            s_q     <= s_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        s_d     = s_q;
        k_d     = k_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (too_big) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = num_steps;
                        k_d     = '0;
                        state_d = ST_INIT;
                    end
                end
            end
            ST_INIT: begin
                if (k_ext == w_n - 17'd1) begin
                    k_d     = '0;
                    s_d     = n_q - 16'd1;
                    state_d = (n_q == '0) ? ST_FIN : ST_SWEEP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (k_ext == w_s) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // the next layer may only read once this layer's last write has left the delay line
                if (k_ext == 17'(RD_LAT - 1)) begin
                    k_d     = '0;
                    s_d     = s_q - 16'd1;
                    state_d = (s_q == '0) ? ST_FIN : ST_SWEEP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_INIT) || (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
        done    = (state_q == ST_FIN);
        err     = err_q;
        init_en = (state_q == ST_INIT);
        rd_en   = (state_q == ST_SWEEP) && (k_ext < r_s);
        rd_addr = rd_en ? k_q[ADDR_W-1:0] : '0;
        rd_bank = rd_en & ~s_q[0];
        wr_en   = dl_valid;
        wr_addr = dl_addr;
        wr_mask = dl_mask;
        wr_step = dl_step;
        wr_bank = dl_step[0];
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = k_q[ADDR_W-1:0];
            wr_mask = lane_mask(k_ext, n_q);
            wr_step = n_q;
            wr_bank = n_q[0];
        end
    end

`ifdef LATTICE_SWEEP_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == ST_IDLE) && start && !too_big) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_lattice_sweep_ctrl.sv
// tb/tb_lattice_sweep_ctrl.sv - self-checking bench for lattice_sweep_ctrl
module tb_lattice_sweep_ctrl;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 1;
    localparam int MAXC   = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       num_steps = '0;
    logic              busy, done, err, init_en, rd_en, wr_en, rd_bank, wr_bank;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [3:0]        wr_mask;
    logic [15:0]       wr_step;

    always #5 clk = ~clk;

    lattice_sweep_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_steps (num_steps),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .init_en   (init_en),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .rd_bank   (rd_bank),
        .wr_bank   (wr_bank),
        .wr_step   (wr_step)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        exp_busy [MAXC];
    logic        exp_done [MAXC];
    logic        exp_init [MAXC];
    logic        exp_rd   [MAXC];
    logic        exp_wr   [MAXC];
    logic        exp_rbank[MAXC];
    logic        exp_wbank[MAXC];
    logic [7:0]  exp_raddr[MAXC];
    logic [7:0]  exp_waddr[MAXC];
    logic [3:0]  exp_mask [MAXC];
    logic [15:0] exp_step [MAXC];
    int          model_t;
    bit          chk_on = 1'b0;
    int          cyc = 0;

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    function automatic int cdiv4(input int x);
        return (x + 3) / 4;
    endfunction

    function automatic logic [3:0] m_mask(input int g, input int s);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (4 * g + i <= s);
        return m;
    endfunction

    // timeline of every output, cycle 1 = first cycle after the accepted start
    task automatic build_model(input int n);
        int t, w, r, c, wn;
        for (int i = 0; i < MAXC; i++) begin
            exp_busy[i] = 0; exp_done[i] = 0; exp_init[i] = 0; exp_rd[i] = 0;
            exp_wr[i] = 0; exp_rbank[i] = 0; exp_wbank[i] = 0; exp_raddr[i] = '0;
            exp_waddr[i] = '0; exp_mask[i] = '0; exp_step[i] = '0;
        end
        wn = cdiv4(n + 1);
        for (int g = 0; g < wn; g++) begin
            c = 1 + g;
            exp_busy[c] = 1; exp_init[c] = 1; exp_wr[c] = 1;
            exp_waddr[c] = 8'(g); exp_mask[c] = m_mask(g, n);
            exp_step[c] = 16'(n); exp_wbank[c] = 1'(n % 2);
        end
        t = wn + 1;
        for (int s = n - 1; s >= 0; s--) begin
            w = cdiv4(s + 1);
            r = cdiv4(s + 2);
            for (int j = 0; j < w + 1 + RD_LAT; j++) exp_busy[t + j] = 1;
            for (int k = 0; k <= w; k++) begin
                if (k < r) begin
                    exp_rd[t + k] = 1; exp_raddr[t + k] = 8'(k); exp_rbank[t + k] = 1'((s + 1) % 2);
                end
                if (k >= 1) begin
                    c = t + k + RD_LAT;
                    exp_wr[c] = 1; exp_waddr[c] = 8'(k - 1); exp_mask[c] = m_mask(k - 1, s);
                    exp_step[c] = 16'(s); exp_wbank[c] = 1'(s % 2);
                end
            end
            t += w + 1 + RD_LAT;
        end
        exp_done[t] = 1;
        model_t = t - 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",    cyc, 64'(busy),    64'(exp_busy[cyc]));
            chk("done",    cyc, 64'(done),    64'(exp_done[cyc]));
            chk("err",     cyc, 64'(err),     64'd0);
            chk("init_en", cyc, 64'(init_en), 64'(exp_init[cyc]));
            chk("rd_en",   cyc, 64'(rd_en),   64'(exp_rd[cyc]));
            chk("rd_addr", cyc, 64'(rd_addr), 64'(exp_raddr[cyc]));
            chk("rd_bank", cyc, 64'(rd_bank), 64'(exp_rbank[cyc]));
            chk("wr_en",   cyc, 64'(wr_en),   64'(exp_wr[cyc]));
            chk("wr_addr", cyc, 64'(wr_addr), 64'(exp_waddr[cyc]));
            chk("wr_mask", cyc, 64'(wr_mask), 64'(exp_mask[cyc]));
            chk("wr_step", cyc, 64'(wr_step), 64'(exp_step[cyc]));
            chk("wr_bank", cyc, 64'(wr_bank), 64'(exp_wbank[cyc]));
            cyc++;
        end
    end

    // poke: extra start pulses during busy and in the FIN cycle, with a different N
    task automatic run_sweep(input int n, input bit poke);
        build_model(n);
        @(negedge clk);
        num_steps = 16'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cyc    = 1;
        chk_on = 1'b1;
        for (int i = 1; i <= model_t + 3; i++) begin
            start = poke && (i == 3 || i == model_t + 1);
            if (poke) num_steps = 16'(n + 9);
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        chk_on = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, err, init_en, rd_en, rd_addr, wr_en, wr_addr,
                    wr_mask, rd_bank, wr_bank, wr_step});
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 0, all_outs(), 64'd0);
        rst_n = 1'b1;

        build_model(3);
        chk("model_T_n3",      0, 64'(model_t),     64'd10);
        chk("model_done_n3",   11, 64'(exp_done[11]), 64'd1);
        chk("model_mask_s2",   4, 64'(exp_mask[4]),  64'h7);
        chk("model_rbank_s2",  2, 64'(exp_rbank[2]), 64'd1);
        chk("model_mask_s0",   10, 64'(exp_mask[10]), 64'h1);
        run_sweep(3, 1'b0);

        build_model(5);
        chk("model_raddr_s4",  4, 64'(exp_raddr[4]), 64'd1);
        chk("model_mask_g1s4", 6, 64'(exp_mask[6]),  64'h1);
        chk("model_mask_g0s4", 5, 64'(exp_mask[5]),  64'hf);
        chk("model_step_s4",   6, 64'(exp_step[6]),  64'd4);
        run_sweep(5, 1'b0);

        build_model(0);
        chk("model_T_n0",      0, 64'(model_t),     64'd1);
        chk("model_mask_n0",   1, 64'(exp_mask[1]),  64'h1);
        run_sweep(0, 1'b0);

        run_sweep(12, 1'b0);
        run_sweep(7, 1'b1);
        run_sweep(4, 1'b0);

        // N too large for the group address space
        @(negedge clk);
        num_steps = 16'd1023;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("err_pulse",  1, 64'(err),  64'd1);
        chk("err_busy",   1, 64'(busy), 64'd0);
        @(negedge clk);
        chk("err_clear",  2, 64'(err),  64'd0);
        chk("err_busy2",  2, 64'(busy), 64'd0);

        // largest legal N is accepted, then aborted by reset
        num_steps = 16'd1022;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("n1022_busy", 1, 64'(busy),    64'd1);
        chk("n1022_init", 1, 64'(init_en), 64'd1);
        chk("n1022_step", 1, 64'(wr_step), 64'd1022);
        chk("n1022_err",  1, 64'(err),     64'd0);
        rst_n = 1'b0;
        #1 chk("n1022_rst", 1, all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset mid-sweep at cycle 6 of N=7
        @(negedge clk);
        num_steps = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_wr_en",   6, 64'(wr_en),   64'd1);
        chk("mid_wr_addr", 6, 64'(wr_addr), 64'd1);
        chk("mid_wr_mask", 6, 64'(wr_mask), 64'h7);
        rst_n = 1'b0;
        #1 chk("mid_rst_outs", 6, all_outs(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_nodone", 7 + i, all_outs(), 64'd0);
        end
        rst_n = 1'b1;
        run_sweep(7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
